// File: rtl/frame_fetch.sv
// Pixel prefetch stage: fetches RGB pixels from frame memory over a req/ack port
// into a first-word-fall-through FIFO feeding the HDMI timing block.
module frame_fetch #(
    parameter int ADDR_W       = 20,
    parameter int FRAME_PIXELS = 307200,
    parameter int DEPTH        = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        vsync,
    input  logic                        pix_read,
    output logic [23:0]                 pix_data,
    output logic                        rd_req,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic                        rd_ack,
    input  logic [23:0]                 rd_data,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        underflow,
    output logic                        frame_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [LW-1:0]     FULL_LVL  = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              underflow_q, underflow_d;
    logic              flush_req_q, flush_req_d;
    logic              vsync_d_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d, level_nxt;
    logic [23:0]       mem_q [DEPTH];
    logic              vsync_fall, push, pop, flush;

    assign vsync_fall = vsync_d_q & ~vsync;

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        frame_done_d = frame_done_q;
        flush_req_d  = flush_req_q | vsync_fall;
        push         = 1'b0;
        flush        = 1'b0;
        // FLUSH owns the cycle: reads are ignored and cannot flag underflow
        pop          = pix_read && (level_q != '0) && (state_q != FLUSH);
        underflow_d  = underflow_q | (pix_read && (level_q == '0) && (state_q != FLUSH));

        if (state_q == REQ && rd_ack && !flush_req_q) push = 1'b1;
        level_nxt = level_q + LW'(push) - LW'(pop);

        case (state_q)
            IDLE: begin
                if (flush_req_q)
                    state_d = FLUSH;
                else if (level_q < FULL_LVL && rd_addr_q <= LAST_ADDR && !frame_done_q)
                    state_d = REQ;
            end
            REQ: begin
                if (rd_ack) begin
                    if (push) begin
                        if (rd_addr_q == LAST_ADDR) frame_done_d = 1'b1;
                        else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                    if (flush_req_q)
                        state_d = FLUSH;
                    else if (level_nxt < FULL_LVL && !frame_done_d)
                        state_d = REQ;
                    else
                        state_d = IDLE;
                end
            end
            FLUSH: begin
                flush        = 1'b1;
                rd_addr_d    = '0;
                frame_done_d = 1'b0;
                flush_req_d  = vsync_fall;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            level_d  = level_nxt;
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            flush_req_q  <= 1'b0;
            vsync_d_q    <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            flush_req_q  <= flush_req_d;
            vsync_d_q    <= vsync;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Storage needs no reset; the level counter gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end

    assign pix_data   = (level_q != '0) ? mem_q[rd_ptr_q] : 24'h000000;
    assign rd_req     = (state_q == REQ);
    assign rd_addr    = rd_addr_q;
    assign fifo_level = level_q;
    assign underflow  = underflow_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_frame_fetch.sv
// Directed bench for frame_fetch: fill, drain order, underflow, flush, frame end.
module tb_frame_fetch;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vsync = 1'b1;
    logic        pix_read = 1'b0;
    logic [23:0] pix_data;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_ack;
    logic [23:0] rd_data;
    logic [4:0]  fifo_level;
    logic        underflow;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    // memory model: acks ack_lat cycles after rd_req rises, data = {A, addr}
    logic ack_en = 1'b0;
    int   ack_lat = 0;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rd_req || rd_ack) wait_cnt <= 0;
        else                   wait_cnt <= wait_cnt + 1;
    end
    assign rd_ack  = ack_en && rd_req && (wait_cnt >= ack_lat);
    assign rd_data = {4'hA, rd_addr};

    frame_fetch #(.ADDR_W(20), .FRAME_PIXELS(700), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .vsync(vsync), .pix_read(pix_read),
        .pix_data(pix_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .fifo_level(fifo_level),
        .underflow(underflow), .frame_done(frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        ack_en = 1'b0;
        rstn = 1'b0;
        step();
        step();
        total++; if (rd_req !== 1'b0)     begin bad++; $display("FAIL reset_rd_req got=%b want=0", rd_req); end
        total++; if (rd_addr !== 20'd0)   begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
        total++; if (pix_data !== 24'd0)  begin bad++; $display("FAIL reset_pix_data got=%h want=0", pix_data); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        total++; if (underflow !== 1'b0)  begin bad++; $display("FAIL reset_underflow got=%b want=0", underflow); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    endtask

    task automatic test_fill_lat0();
        ack_en = 1'b1; ack_lat = 0;
        rstn = 1'b1;
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL fill0_pre_req got=%b want=0", rd_req); end
        step();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rd_req !== 1'b1 || rd_addr !== 20'(i)) begin
                bad++; $display("FAIL fill0_req[%0d] got req=%b addr=%0d want req=1 addr=%0d", i, rd_req, rd_addr, i);
            end
            step();
        end
        total++; if (rd_req !== 1'b0)          begin bad++; $display("FAIL fill0_req_drop got=%b want=0", rd_req); end
        total++; if (fifo_level !== 5'd16)     begin bad++; $display("FAIL fill0_level got=%0d want=16", fifo_level); end
        total++; if (pix_data !== 24'hA00000)  begin bad++; $display("FAIL fill0_head got=%h want=a00000", pix_data); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL fill0_full_idle[%0d] got=%b want=0", i, rd_req); end
        end
    endtask

    task automatic test_fill_lat3();
        ack_lat = 3;
        do_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (rd_req !== 1'b1 || rd_addr !== 20'(i)) begin
                    bad++; $display("FAIL fill3_hold[%0d.%0d] got req=%b addr=%0d want req=1 addr=%0d", i, k, rd_req, rd_addr, i);
                end
                step();
            end
        end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fill3_level got=%0d want=16", fifo_level); end
        for (int i = 0; i < 5; i++) begin
            total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL fill3_full_idle[%0d] got=%b want=0", i, rd_req); end
            step();
        end
    endtask

    task automatic test_drain();
        logic [23:0] exp;
        ack_lat = 0;
        pix_read = 1'b1;
        for (int k = 0; k < 640; k++) begin
            exp = {4'hA, k[19:0]};
            total++;
            if (pix_data !== exp) begin
                bad++; $display("FAIL drain[%0d] got=%h want=%h", k, pix_data, exp);
            end
            step();
        end
        pix_read = 1'b0;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_underflow got=%b want=0", underflow); end
        for (int i = 0; i < 6; i++) step();
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL drain_refill got=%0d want=16", fifo_level); end
    endtask

    task automatic test_underflow();
        logic [23:0] exp;
        ack_en = 1'b0;
        pix_read = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = {4'hA, 20'(640 + k)};
            total++;
            if (pix_data !== exp) begin bad++; $display("FAIL uf_pop[%0d] got=%h want=%h", k, pix_data, exp); end
            step();
        end
        for (int k = 0; k < 20; k++) begin
            total++;
            if (pix_data !== 24'd0) begin bad++; $display("FAIL uf_data[%0d] got=%h want=0", k, pix_data); end
            step();
        end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b want=1", underflow); end
        pix_read = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 24; i++) step();
        total++; if (underflow !== 1'b1)   begin bad++; $display("FAIL uf_sticky got=%b want=1", underflow); end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL uf_refill got=%0d want=16", fifo_level); end
        total++; if (rd_addr !== 20'd672)  begin bad++; $display("FAIL uf_addr got=%0d want=672", rd_addr); end
    endtask

    task automatic test_flush_mid();
        logic [4:0] lvl_before;
        bit found;
        // frame restart from a full FIFO
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL vs_flush_req got=%b want=0", rd_req); end
        step();
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL vs_level got=%0d want=0", fifo_level); end
        total++; if (rd_addr !== 20'd0)   begin bad++; $display("FAIL vs_addr got=%0d want=0", rd_addr); end
        total++; if (underflow !== 1'b1)  begin bad++; $display("FAIL vs_uf_kept got=%b want=1", underflow); end
        step();
        total++; if (rd_req !== 1'b1 || rd_addr !== 20'd0) begin
            bad++; $display("FAIL vs_first_req got req=%b addr=%0d want req=1 addr=0", rd_req, rd_addr);
        end
        // stream until the request for address 37 is on the bus, then stall it
        pix_read = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_req && rd_addr == 20'd37) begin found = 1'b1; break; end
            step();
        end
        total++; if (!found) begin bad++; $display("FAIL mid_reach37 got=timeout want=req@37"); end
        ack_en = 1'b0;
        pix_read = 1'b0;
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        total++; if (rd_req !== 1'b1 || rd_addr !== 20'd37) begin
            bad++; $display("FAIL mid_hold got req=%b addr=%0d want req=1 addr=37", rd_req, rd_addr);
        end
        step();
        total++; if (rd_req !== 1'b1 || rd_addr !== 20'd37) begin
            bad++; $display("FAIL mid_hold2 got req=%b addr=%0d want req=1 addr=37", rd_req, rd_addr);
        end
        lvl_before = fifo_level;
        ack_en = 1'b1;
        step();
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL mid_flush_cycle got=%b want=0", rd_req); end
        total++; if (fifo_level !== lvl_before) begin
            bad++; $display("FAIL mid_discard got=%0d want=%0d", fifo_level, lvl_before);
        end
        step();
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
        total++; if (pix_data !== 24'd0)  begin bad++; $display("FAIL mid_data got=%h want=0", pix_data); end
        step();
        total++; if (rd_req !== 1'b1 || rd_addr !== 20'd0) begin
            bad++; $display("FAIL mid_restart got req=%b addr=%0d want req=1 addr=0", rd_req, rd_addr);
        end
    endtask

    task automatic test_frame_end();
        int last_ack;
        int extra_req;
        bit found;
        last_ack = -1;
        extra_req = 0;
        found = 1'b0;
        pix_read = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rd_req && rd_ack) last_ack = int'(rd_addr);
            step();
            if (frame_done) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL fe_done got=timeout want=frame_done"); end
        total++; if (last_ack != 699) begin bad++; $display("FAIL fe_last_ack got=%0d want=699", last_ack); end
        total++; if (rd_addr !== 20'd699) begin bad++; $display("FAIL fe_addr got=%0d want=699", rd_addr); end
        for (int i = 0; i < 40; i++) begin
            if (rd_req) extra_req++;
            step();
        end
        total++; if (extra_req != 0) begin bad++; $display("FAIL fe_no_req got=%0d want=0", extra_req); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL fe_done_held got=%b want=1", frame_done); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL fe_drained got=%0d want=0", fifo_level); end
        pix_read = 1'b0;
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        step();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fe_cleared got=%b want=0", frame_done); end
        step();
        total++; if (rd_req !== 1'b1 || rd_addr !== 20'd0) begin
            bad++; $display("FAIL fe_restart got req=%b addr=%0d want req=1 addr=0", rd_req, rd_addr);
        end
    endtask

    initial begin
        test_reset();
        test_fill_lat0();
        test_fill_lat3();
        test_drain();
        test_underflow();
        test_flush_mid();
        test_frame_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
